// File: rtl/led_key_driver.sv
// ----------------------------------------------------------------------------
// led_key_driver
//
// Purpose:
//   Maps 8 raw push-button inputs onto 8 LED outputs, bit i to bit i. Each key
//   passes through a two-flop synchronizer and a per-bit debounce counter, and
//   the accepted level is then registered onto its LED. No combinational path
//   exists from key to led.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive cycles a synchronized level must hold before
//                     it is accepted (2..65535)
//   CNT_W           : width of each debounce counter (2^CNT_W > DEBOUNCE_CYCLES)
//   LED_ACTIVE_LOW  : 1 inverts the LED drive (lit = 0, dark = 1)
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   key : raw asynchronous key levels, 1 = pressed
//   led : registered LED drive
//
// Build option:
//   LED_TOGGLE_EN : when defined, each accepted key press toggles its LED and
//                   releases are ignored; otherwise the LED mirrors the
//                   debounced key level.
// ----------------------------------------------------------------------------
module led_key_driver #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter bit          LED_ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    output logic [7:0] led
);

    localparam logic [7:0]       LED_POL  = LED_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       r_s1;
    logic [7:0]       r_s2;
    logic [7:0]       r_deb;
    logic [CNT_W-1:0] r_cnt [8];
    logic [7:0]       r_led;
`ifdef LED_TOGGLE_EN
    logic [7:0]       r_deb_d;
    logic [7:0]       r_tog;
`endif

    assign led = r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_deb <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_cnt[i] <= '0;
            end
`ifdef LED_TOGGLE_EN
            r_deb_d <= '0;
            r_tog   <= '0;
`endif
            r_led <= LED_POL;
        end else begin
            r_s1 <= key;
            r_s2 <= r_s1;

            // A level equal to the accepted state clears the count, so any
            // bounce back before acceptance restarts the window from zero.
            for (int unsigned i = 0; i < 8; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end

`ifdef LED_TOGGLE_EN
            // Rising edge of the debounced level flips the toggle state;
            // this adds one cycle of latency relative to mirror mode.
            r_deb_d <= r_deb;
            r_tog   <= r_tog ^ (r_deb & ~r_deb_d);
            r_led   <= r_tog ^ LED_POL;
`else
            r_led   <= r_deb ^ LED_POL;
`endif
        end
    end

endmodule

// File: tb/tb_led_key_driver.sv
// ----------------------------------------------------------------------------
// tb_led_key_driver
//
// Self-checking bench for led_key_driver with default parameters and a 10 ns
// clock. Stimulus records the expected LED value for specific cycle numbers in
// a scoreboard; a monitor on the falling edge compares every entry that falls
// due on the current cycle. Cycle numbers count rising edges since time zero.
// ----------------------------------------------------------------------------
module tb_led_key_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key;
    logic [7:0] led;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  val;
        string       name;
    } exp_t;

    exp_t sb[$];

    led_key_driver #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W          (16),
        .LED_ACTIVE_LOW (1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .led(led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every scoreboard entry due on this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_tests++;
                if (led !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d led=%h expected %h",
                             sb[i].name, cyc, led, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int unsigned c, input logic [7:0] v,
                             input string nm);
        exp_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending",
                 sb.size());
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned c1;
        logic [7:0]  prev;
        logic [7:0]  v;
        logic [7:0]  g_val [6];
        int unsigned g_len [6];

        rst = 1'b1;
        key = 8'hFF;

`ifdef LED_TOGGLE_EN
        @(negedge clk);
        wait_until(20);
        rst = 1'b0;
        key = 8'h00;
        wait_until(40);

        // Press / release key[3] twice, 40 cycles per level.
        c0 = cyc;
        key = 8'h08;
        expect_at(c0 + 19, 8'h00, "tog_first_pre");
        expect_at(c0 + 20, 8'h08, "tog_first_on");
        expect_at(c0 + 39, 8'h08, "tog_first_hold");
        wait_until(c0 + 40);
        key = 8'h00;
        expect_at(c0 + 40 + 25, 8'h08, "tog_release1");
        expect_at(c0 + 40 + 39, 8'h08, "tog_release1_end");
        wait_until(c0 + 80);
        key = 8'h08;
        expect_at(c0 + 80 + 19, 8'h08, "tog_second_pre");
        expect_at(c0 + 80 + 20, 8'h00, "tog_second_off");
        wait_until(c0 + 120);
        key = 8'h00;
        expect_at(c0 + 120 + 25, 8'h00, "tog_release2");
        expect_at(c0 + 120 + 39, 8'h00, "tog_release2_end");
        wait_until(c0 + 160);
`else
        // Reset held 100 cycles with all keys pressed.
        for (int unsigned c = 2; c <= 100; c += 7)
            expect_at(c, 8'h00, "reset_hold");
        @(negedge clk);
        wait_until(100);
        rst = 1'b0;
        key = 8'h00;
        c0 = cyc;
        for (int unsigned k = 1; k <= 40; k += 5)
            expect_at(c0 + k, 8'h00, "post_reset");
        wait_until(c0 + 40);

        // Walking one, each value held 50 cycles.
        prev = 8'h00;
        for (int unsigned i = 0; i < 8; i++) begin
            c0 = cyc;
            v = 8'(1 << i);
            key = v;
            expect_at(c0 + 18, prev, "walk_pre");
            expect_at(c0 + 19, v,    "walk_on");
            expect_at(c0 + 49, v,    "walk_hold");
            prev = v;
            wait_until(c0 + 50);
        end
        c0 = cyc;
        key = 8'h00;
        expect_at(c0 + 18, 8'h80, "walk_end_pre");
        expect_at(c0 + 19, 8'h00, "walk_end");
        expect_at(c0 + 40, 8'h00, "walk_end_hold");
        wait_until(c0 + 50);

        // Multi-bit: 00 -> F0 (50 cycles) -> 93 (100 cycles); bits 7 and 4
        // are checked every cycle across the second change.
        c0 = cyc;
        key = 8'hF0;
        expect_at(c0 + 18, 8'h00, "multi_f0_pre");
        expect_at(c0 + 19, 8'hF0, "multi_f0_on");
        wait_until(c0 + 50);
        c1 = cyc;
        key = 8'h93;
        for (int unsigned k = 1; k <= 30; k++)
            expect_at(c1 + k, (k < 19) ? 8'hF0 : 8'h93, "multi_93_seq");
        expect_at(c1 + 99, 8'h93, "multi_93_hold");
        wait_until(c1 + 100);
        c0 = cyc;
        key = 8'h00;
        expect_at(c0 + 19, 8'h00, "multi_clear");
        wait_until(c0 + 40);

        // Glitch reject: 8-cycle pulse, gap, then a 15-cycle bounce burst.
        g_val[0] = 8'h01; g_len[0] = 8;
        g_val[1] = 8'h00; g_len[1] = 20;
        g_val[2] = 8'h01; g_len[2] = 5;
        g_val[3] = 8'h00; g_len[3] = 2;
        g_val[4] = 8'h01; g_len[4] = 7;
        g_val[5] = 8'h00; g_len[5] = 1;
        c0 = cyc;
        for (int unsigned k = 1; k <= 80; k++)
            expect_at(c0 + k, 8'h00, "glitch_reject");
        for (int unsigned s = 0; s < 6; s++) begin
            c1 = cyc;
            key = g_val[s];
            wait_until(c1 + g_len[s]);
        end
        key = 8'h00;
        wait_until(c0 + 85);

        // Reset mid-debounce: one reset cycle 10 cycles into a press.
        c0 = cyc;
        key = 8'h20;
        expect_at(c0 + 5,  8'h00, "rst_mid_pre");
        expect_at(c0 + 12, 8'h00, "rst_mid_after");
        expect_at(c0 + 20, 8'h00, "rst_mid_discard");
        expect_at(c0 + 29, 8'h00, "rst_mid_last_off");
        expect_at(c0 + 30, 8'h20, "rst_mid_on");
        expect_at(c0 + 50, 8'h20, "rst_mid_hold");
        wait_until(c0 + 10);
        rst = 1'b1;
        wait_until(c0 + 11);
        rst = 1'b0;
        wait_until(c0 + 55);
`endif

        // Drain remaining scoreboard entries with a bounded wait.
        c0 = cyc;
        while (sb.size() != 0 && cyc < c0 + 200) @(negedge clk);
        if (sb.size() != 0) begin
            for (int i = 0; i < sb.size(); i++) begin
                n_fail++;
                $display("FAIL %s: check at cycle %0d never reached, expected %h",
                         sb[i].name, sb[i].cyc, sb[i].val);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
